// File: rtl/avl_ddr_arbiter.sv
// Two-master round-robin arbiter for the shared DDR3 Avalon-MM slave port.
// Read returns are steered back to the issuing master by an in-order owner FIFO.
module avl_ddr_arbiter #(
  parameter int AVL_ADDR_WIDTH    = 29,
  parameter int AVL_DATA_WIDTH    = 512,
  parameter int AVL_BYTE_EN_WIDTH = AVL_DATA_WIDTH/8,
  parameter int MAX_RUN           = 4,
  parameter int MAX_OUTSTANDING   = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [AVL_ADDR_WIDTH-1:0]          m0_address,
  input  logic [AVL_DATA_WIDTH-1:0]          m0_writedata,
  input  logic [AVL_BYTE_EN_WIDTH-1:0]       m0_byteenable,
  input  logic                               m0_write,
  input  logic                               m0_read,
  output logic                               m0_waitrequest,
  output logic [AVL_DATA_WIDTH-1:0]          m0_readdata,
  output logic                               m0_readdatavalid,
  input  logic [AVL_ADDR_WIDTH-1:0]          m1_address,
  input  logic [AVL_DATA_WIDTH-1:0]          m1_writedata,
  input  logic [AVL_BYTE_EN_WIDTH-1:0]       m1_byteenable,
  input  logic                               m1_write,
  input  logic                               m1_read,
  output logic                               m1_waitrequest,
  output logic [AVL_DATA_WIDTH-1:0]          m1_readdata,
  output logic                               m1_readdatavalid,
  output logic [AVL_ADDR_WIDTH-1:0]          avl_address,
  output logic [AVL_DATA_WIDTH-1:0]          avl_writedata,
  output logic [AVL_BYTE_EN_WIDTH-1:0]       avl_byteenable,
  output logic                               avl_write,
  output logic                               avl_read,
  input  logic [AVL_DATA_WIDTH-1:0]          avl_readdata,
  input  logic                               avl_readdatavalid,
  input  logic                               avl_waitrequest,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_unexpected_rdv
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam int RW = (MAX_RUN > 1) ? $clog2(MAX_RUN) : 1;
  localparam logic [RW-1:0] RUN_LAST = RW'(MAX_RUN - 1);
  localparam logic [CW-1:0] OUT_MAX  = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            prio_q, prio_d;
  logic [RW-1:0]   run_q, run_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic            owner_q [MAX_OUTSTANDING];
  logic            err_q;

  logic req0, req1;
  logic empty, rd_full;
  logic accept, push, pop;
  logic head;

  assign req0  = m0_read | m0_write;
  assign req1  = m1_read | m1_write;
  assign empty = (cnt_q == '0);
  // A return beat in the same cycle frees a slot for the stalled read.
  assign rd_full = (cnt_q == OUT_MAX) & ~avl_readdatavalid;

  assign accept = (avl_read | avl_write) & ~avl_waitrequest;
  assign push   = accept & avl_read;
  assign pop    = avl_readdatavalid & ~empty;
  assign head   = owner_q[rptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    run_d   = run_q;
    unique case (state_q)
      IDLE: begin
        if (req0 & req1)
          state_d = prio_q ? GNT1 : GNT0;
        else if (req0)
          state_d = GNT0;
        else if (req1)
          state_d = GNT1;
      end
      GNT0: begin
        if (!req0) begin
          state_d = req1 ? GNT1 : IDLE;
          prio_d  = 1'b1;
          run_d   = '0;
        end else if (accept) begin
          if (run_q == RUN_LAST) begin
            run_d = '0;
            if (req1) begin
              state_d = GNT1;
              prio_d  = 1'b1;
            end
          end else begin
            run_d = run_q + RW'(1);
          end
        end
      end
      GNT1: begin
        if (!req1) begin
          state_d = req0 ? GNT0 : IDLE;
          prio_d  = 1'b0;
          run_d   = '0;
        end else if (accept) begin
          if (run_q == RUN_LAST) begin
            run_d = '0;
            if (req0) begin
              state_d = GNT0;
              prio_d  = 1'b0;
            end
          end else begin
            run_d = run_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    avl_address    = m0_address;
    avl_writedata  = m0_writedata;
    avl_byteenable = m0_byteenable;
    avl_write      = 1'b0;
    avl_read       = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    unique case (state_q)
      GNT0: begin
        avl_write      = m0_write;
        avl_read       = m0_read & ~rd_full;
        m0_waitrequest = avl_waitrequest | (m0_read & rd_full);
      end
      GNT1: begin
        avl_address    = m1_address;
        avl_writedata  = m1_writedata;
        avl_byteenable = m1_byteenable;
        avl_write      = m1_write;
        avl_read       = m1_read & ~rd_full;
        m1_waitrequest = avl_waitrequest | (m1_read & rd_full);
      end
      default: ;
    endcase
  end

  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push)
        wptr_q <= wptr_q + PW'(1);
      if (pop)
        rptr_q <= rptr_q + PW'(1);
      if (avl_readdatavalid & empty)
        err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      owner_q[wptr_q] <= (state_q == GNT1);
  end

  assign m0_readdata      = avl_readdata;
  assign m1_readdata      = avl_readdata;
  assign m0_readdatavalid = pop & ~head;
  assign m1_readdatavalid = pop & head;

  assign outstanding        = cnt_q;
  assign err_unexpected_rdv = err_q;

endmodule

// File: tb/tb_avl_ddr_arbiter.sv
// Bench for avl_ddr_arbiter: master/slave BFMs feed a scoreboard that
// checks forwarding, run limits, read routing and outstanding count.
module tb_avl_ddr_arbiter;

  localparam int AW      = 29;
  localparam int DW      = 512;
  localparam int BW      = 64;
  localparam int MAX_RUN = 4;
  localparam int MAXO    = 16;

  typedef struct {
    bit            rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
  } cmd_t;

  typedef struct {
    bit            own;
    logic [DW-1:0] d;
  } ret_t;

  typedef struct {
    int c;
    int m;
  } log_t;

  logic clk;
  logic rst;
  logic [AW-1:0] m0_address, m1_address, avl_address;
  logic [DW-1:0] m0_writedata, m1_writedata, avl_writedata;
  logic [BW-1:0] m0_byteenable, m1_byteenable, avl_byteenable;
  logic m0_write, m0_read, m0_waitrequest, m0_readdatavalid;
  logic m1_write, m1_read, m1_waitrequest, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata, avl_readdata;
  logic avl_write, avl_read, avl_readdatavalid, avl_waitrequest;
  logic [4:0] outstanding;
  logic err_unexpected_rdv;

  avl_ddr_arbiter #(
    .AVL_ADDR_WIDTH(AW),
    .AVL_DATA_WIDTH(DW),
    .AVL_BYTE_EN_WIDTH(BW),
    .MAX_RUN(MAX_RUN),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .m0_address(m0_address),
    .m0_writedata(m0_writedata),
    .m0_byteenable(m0_byteenable),
    .m0_write(m0_write),
    .m0_read(m0_read),
    .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address),
    .m1_writedata(m1_writedata),
    .m1_byteenable(m1_byteenable),
    .m1_write(m1_write),
    .m1_read(m1_read),
    .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .avl_address(avl_address),
    .avl_writedata(avl_writedata),
    .avl_byteenable(avl_byteenable),
    .avl_write(avl_write),
    .avl_read(avl_read),
    .avl_readdata(avl_readdata),
    .avl_readdatavalid(avl_readdatavalid),
    .avl_waitrequest(avl_waitrequest),
    .outstanding(outstanding),
    .err_unexpected_rdv(err_unexpected_rdv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cmd_t dq0[$], dq1[$], exp0[$], exp1[$];
  ret_t exp_ret[$];
  logic [DW-1:0] slv_q[$];
  log_t log_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit acc0_s = 0, acc1_s = 0;
  bit rand_gaps = 0, wr_rand = 0, wr_force = 0, ret_rand = 0;
  int ret_req = 0;
  int ret_done = 0;
  int model_cnt = 0;
  bit err_m = 0;
  int streak0 = 0, streak1 = 0;

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic cmd_t mk(bit rd, logic [AW-1:0] a);
    cmd_t c;
    c.rd = rd;
    c.a  = a;
    c.d  = rnd_data();
    c.be = {$urandom, $urandom};
    return c;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic chk_w(string nm, logic [DW-1:0] act, logic [DW-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic push_cmd(int x, cmd_t c);
    if (x == 0) begin dq0.push_back(c); exp0.push_back(c); end
    else begin dq1.push_back(c); exp1.push_back(c); end
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  // Master and slave BFMs: inputs change just after the rising edge.
  initial begin
    cmd_t c;
    bit gap0, gap1;
    m0_address = '0; m0_writedata = '0; m0_byteenable = '0;
    m0_write = 0; m0_read = 0;
    m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
    m1_write = 0; m1_read = 0;
    avl_readdata = '0; avl_readdatavalid = 0; avl_waitrequest = 0;
    forever begin
      @(posedge clk);
      #1;
      gap0 = 0;
      gap1 = 0;
      if (acc0_s && dq0.size() > 0) begin
        dq0.delete(0);
        gap0 = rand_gaps && ($urandom_range(0, 3) == 0);
      end
      if (acc1_s && dq1.size() > 0) begin
        dq1.delete(0);
        gap1 = rand_gaps && ($urandom_range(0, 3) == 0);
      end
      m0_read = 0; m0_write = 0;
      if (!gap0 && dq0.size() > 0) begin
        c = dq0[0];
        m0_read = c.rd; m0_write = !c.rd;
        m0_address = c.a; m0_writedata = c.d; m0_byteenable = c.be;
      end
      m1_read = 0; m1_write = 0;
      if (!gap1 && dq1.size() > 0) begin
        c = dq1[0];
        m1_read = c.rd; m1_write = !c.rd;
        m1_address = c.a; m1_writedata = c.d; m1_byteenable = c.be;
      end
      avl_waitrequest = wr_rand ? ($urandom_range(0, 3) == 0) : wr_force;
      avl_readdatavalid = 0;
      if (slv_q.size() > 0 &&
          (ret_done < ret_req || (ret_rand && $urandom_range(0, 2) == 0))) begin
        avl_readdatavalid = 1;
        avl_readdata = slv_q.pop_front();
        if (ret_done < ret_req) ret_done++;
      end
    end
  end

  task automatic take(int x, bit other_req, inout int rd_acc);
    cmd_t e;
    bit have;
    logic [DW-1:0] d;
    have = 0;
    if (x == 0 && exp0.size() > 0) begin e = exp0.pop_front(); have = 1; end
    if (x == 1 && exp1.size() > 0) begin e = exp1.pop_front(); have = 1; end
    if (!have) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_cmd: master %0d got a command accepted, expected none", x);
      return;
    end
    chk("cmd_addr", 64'(avl_address), 64'(e.a));
    chk("cmd_read", 64'(avl_read), 64'(e.rd));
    chk("cmd_write", 64'(avl_write), 64'(!e.rd));
    if (!e.rd) begin
      chk_w("cmd_wdata", avl_writedata, e.d);
      chk("cmd_be", 64'(avl_byteenable), 64'(e.be));
    end else begin
      rd_acc++;
      d = rnd_data();
      exp_ret.push_back('{own: x[0], d: d});
      slv_q.push_back(d);
    end
    // While the other master waits, one master may take at most MAX_RUN in a row.
    if (x == 0) begin
      streak1 = 0;
      if (other_req) begin
        streak0++;
        chk("run_limit_m0", 64'(streak0 > MAX_RUN), 64'(0));
      end else streak0 = 0;
    end else begin
      streak0 = 0;
      if (other_req) begin
        streak1++;
        chk("run_limit_m1", 64'(streak1 > MAX_RUN), 64'(0));
      end else streak1 = 0;
    end
    log_q.push_back('{c: cyc, m: x});
  endtask

  task automatic monitor_cycle();
    bit r0, r1, a0, a1, pop_now;
    int rd_acc;
    ret_t r;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    a0 = r0 & ~m0_waitrequest;
    a1 = r1 & ~m1_waitrequest;
    acc0_s = a0;
    acc1_s = a1;
    chk("outstanding", 64'(outstanding), 64'(model_cnt));
    chk("err_flag", 64'(err_unexpected_rdv), 64'(err_m));
    chk("avl_accept", 64'((avl_read | avl_write) & ~avl_waitrequest), 64'(a0 | a1));
    if (a0 && a1) chk("double_grant", 64'(1), 64'(0));
    if (model_cnt == MAXO && !avl_readdatavalid)
      chk("full_stall", 64'(avl_read), 64'(0));
    pop_now = 0;
    if (avl_readdatavalid) begin
      if (exp_ret.size() > 0) begin
        r = exp_ret.pop_front();
        pop_now = 1;
        chk("rdv_m0", 64'(m0_readdatavalid), 64'(!r.own));
        chk("rdv_m1", 64'(m1_readdatavalid), 64'(r.own));
        chk_w("rdata_m0", m0_readdata, r.d);
        chk_w("rdata_m1", m1_readdata, r.d);
      end else begin
        chk("stale_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
        err_m = 1;
      end
    end else begin
      chk("idle_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
    end
    rd_acc = 0;
    if (a0) take(0, r1, rd_acc);
    if (a1) take(1, r0, rd_acc);
    model_cnt = model_cnt + rd_acc - int'(pop_now);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        exp_ret.delete();
        model_cnt = 0;
        err_m = 0;
        streak0 = 0;
        streak1 = 0;
        acc0_s = 0;
        acc1_s = 0;
      end else begin
        monitor_cycle();
      end
    end
  end

  task automatic wait_drain(int maxc, string nm);
    bit done;
    done = 0;
    for (int i = 0; i < maxc; i++) begin
      if (dq0.size() == 0 && dq1.size() == 0 && exp0.size() == 0 &&
          exp1.size() == 0 && exp_ret.size() == 0 && slv_q.size() == 0) begin
        done = 1;
        break;
      end
      at_neg();
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: traffic not drained after %0d cycles, expected drained", nm, maxc);
    end
  endtask

  task automatic wait_acc(int x, int maxc, string nm);
    bit done;
    done = 0;
    for (int i = 0; i < maxc; i++) begin
      if ((x == 0 && exp0.size() == 0) || (x == 1 && exp1.size() == 0)) begin
        done = 1;
        break;
      end
      at_neg();
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: command not accepted in %0d cycles, expected accepted", nm, maxc);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    cmd_t c0;
    bit ok;
    rst = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_avl_write", 64'(avl_write), 64'(0));
    chk("rst_avl_read", 64'(avl_read), 64'(0));
    chk("rst_m0_wait", 64'(m0_waitrequest), 64'(1));
    chk("rst_m1_wait", 64'(m1_waitrequest), 64'(1));
    chk("rst_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_err", 64'(err_unexpected_rdv), 64'(0));
    rst = 1;
    repeat (2) at_neg();

    // 10 back-to-back writes from m0 alone
    log_q.delete();
    base = cyc;
    for (int i = 0; i < 10; i++) push_cmd(0, mk(0, AW'($urandom)));
    wait_drain(40, "t1_drain");
    chk("t1_count", 64'(log_q.size()), 64'(10));
    for (int k = 0; k < log_q.size(); k++) begin
      chk("t1_cycle", 64'(log_q[k].c), 64'(base + 2 + k));
      chk("t1_master", 64'(log_q[k].m), 64'(0));
    end
    repeat (3) at_neg();

    // both masters continuously requesting; prio now favours m1
    log_q.delete();
    base = cyc;
    for (int i = 0; i < 12; i++) begin
      push_cmd(0, mk(0, AW'($urandom)));
      push_cmd(1, mk(0, AW'($urandom)));
    end
    wait_drain(60, "t2_drain");
    chk("t2_count", 64'(log_q.size()), 64'(24));
    for (int k = 0; k < log_q.size(); k++) begin
      chk("t2_cycle", 64'(log_q[k].c), 64'(base + 2 + k));
      chk("t2_master", 64'(log_q[k].m), 64'(((k / 4) % 2 == 0) ? 1 : 0));
    end
    repeat (3) at_neg();

    // 17 reads from m1 without returns
    for (int i = 0; i < 17; i++) push_cmd(1, mk(1, AW'($urandom)));
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (model_cnt == MAXO) begin ok = 1; break; end
      at_neg();
    end
    chk("t3_reach_full", 64'(ok), 64'(1));
    at_neg();
    for (int i = 0; i < 3; i++) begin
      chk("t3_m1_wait", 64'(m1_waitrequest), 64'(1));
      chk("t3_avl_read", 64'(avl_read), 64'(0));
      chk("t3_outstanding", 64'(outstanding), 64'(16));
      at_neg();
    end
    ret_req++;
    at_neg();
    chk("t3_accept_on_pop", 64'(avl_read & ~m1_waitrequest), 64'(1));
    at_neg();
    chk("t3_outstanding_after", 64'(outstanding), 64'(16));
    ret_rand = 1;
    wait_drain(200, "t3_drain");
    ret_rand = 0;
    repeat (3) at_neg();

    // interleaved reads m0, m1, m0 routed back in order
    push_cmd(0, mk(1, AW'(32'h10)));
    wait_acc(0, 20, "t4_r0");
    push_cmd(1, mk(1, AW'(32'h20)));
    wait_acc(1, 20, "t4_r1");
    push_cmd(0, mk(1, AW'(32'h30)));
    wait_acc(0, 20, "t4_r2");
    at_neg();
    chk("t4_outstanding", 64'(outstanding), 64'(3));
    ret_req += 3;
    wait_drain(40, "t4_drain");
    repeat (3) at_neg();

    // slave stalls m0's grant while m1 waits
    log_q.delete();
    base = cyc;
    wr_force = 1;
    c0 = mk(0, AW'($urandom));
    push_cmd(0, c0);
    at_neg();
    push_cmd(1, mk(0, AW'($urandom)));
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk("t5_avl_write", 64'(avl_write), 64'(1));
      chk("t5_avl_addr", 64'(avl_address), 64'(c0.a));
      chk("t5_m0_wait", 64'(m0_waitrequest), 64'(1));
      chk("t5_m1_wait", 64'(m1_waitrequest), 64'(1));
    end
    wr_force = 0;
    wait_drain(20, "t5_drain");
    chk("t5_count", 64'(log_q.size()), 64'(2));
    if (log_q.size() == 2) begin
      chk("t5_first", 64'({log_q[0].c, log_q[0].m}), 64'({base + 7, 0}));
      chk("t5_second", 64'({log_q[1].c, log_q[1].m}), 64'({base + 9, 1}));
    end
    repeat (3) at_neg();

    // randomized mixed traffic
    rand_gaps = 1;
    wr_rand = 1;
    ret_rand = 1;
    for (int i = 0; i < 250; i++) begin
      push_cmd(0, mk(1'($urandom_range(0, 1)), AW'($urandom)));
      push_cmd(1, mk(1'($urandom_range(0, 1)), AW'($urandom)));
    end
    wait_drain(20000, "t6_drain");
    rand_gaps = 0;
    wr_rand = 0;
    ret_rand = 0;
    repeat (3) at_neg();

    // reset with reads in flight
    for (int i = 0; i < 3; i++) push_cmd(0, mk(1, AW'($urandom)));
    wait_acc(0, 30, "t7_reads");
    at_neg();
    chk("t7_pre_outstanding", 64'(outstanding), 64'(3));
    @(posedge clk);
    #1;
    rst = 0;
    at_neg();
    chk("t7_rst_outstanding", 64'(outstanding), 64'(0));
    chk("t7_rst_err", 64'(err_unexpected_rdv), 64'(0));
    chk("t7_rst_read", 64'(avl_read), 64'(0));
    chk("t7_rst_wait", 64'({m0_waitrequest, m1_waitrequest}), 64'(3));
    @(posedge clk);
    #1;
    rst = 1;
    at_neg();
    ret_req += 3;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (slv_q.size() == 0) begin ok = 1; break; end
      at_neg();
    end
    chk("t7_returns_done", 64'(ok), 64'(1));
    at_neg();
    chk("t7_err_sticky", 64'(err_unexpected_rdv), 64'(1));
    chk("t7_outstanding_end", 64'(outstanding), 64'(0));
    repeat (2) at_neg();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
